// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the parameterised UART transmitter:
//   - tx_state_e : transmitter FSM state encoding
//   - PAR_*      : par_mode encodings (2'b11 is treated like PAR_NONE)
//   - parity helpers used when a word is popped from the FIFO
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest legal data word; narrower words are zero-extended before use,
  // which leaves their XOR reduction unchanged.
  localparam int unsigned MAX_DATA_W = 9;

  // A parity cell is sent only for the two explicit parity modes.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Even: XOR of the data bits. Odd: its inverse.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [1:0]            mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous transmit FIFO with a registered occupancy count.
//   Ports:
//     clk_i    : clock, rising edge
//     rst_i    : asynchronous active-high reset (flushes the FIFO)
//     push_i   : write request, ignored when full
//     wdata_i  : word to write
//     pop_i    : read request, ignored when empty
//     rdata_o  : head word (valid whenever empty_o is low)
//     full_o   : level == FIFO_DEPTH
//     empty_o  : level == 0
//     level_o  : entries currently held (one extra bit beyond the pointers)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign empty_o = (level_q == {LW{1'b0}});
  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and level. Pointers are exactly log2(depth) bits wide, so they
  // wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   FIFO-buffered UART transmitter with configurable data width, parity and
//   stop bits. Every bit cell lasts OVERSAMPLE baud_tick pulses.
//   Ports:
//     sys_clk    : clock, rising edge
//     sys_rst    : asynchronous active-high reset (aborts frame, flushes FIFO)
//     baud_tick  : one-cycle enable at OVERSAMPLE x baud rate
//     par_mode   : 00 none, 01 even, 10 odd, 11 none (latched per frame)
//     stop2      : 1 = two stop bits, 0 = one (latched per frame)
//     tx_data    : word to enqueue, sent LSB first
//     tx_valid   : enqueue request, accepted when tx_ready is high
//     tx_ready   : FIFO not full
//     uart_tx    : registered serial line, idle high
//     tx_busy    : registered, high whenever the FSM is not IDLE
//     tx_done    : registered one-cycle pulse after the last stop cell
//     fifo_level : entries currently queued
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          baud_tick,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);

  // FSM and frame registers
  tx_state_e         state_q;
  logic [CW-1:0]     cell_q;
  logic [BW-1:0]     bit_q;
  logic              stop_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              uart_tx_q;
  logic              tx_busy_q;
  logic              tx_done_q;

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  // Cell/frame timing decodes
  logic              cell_end;
  logic              last_bit;
  logic              last_stop;
  logic              frame_end;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;

  assign cell_end  = baud_tick && (cell_q == CW'(OVERSAMPLE - 1));
  assign last_bit  = (bit_q == BW'(DATA_W - 1));
  assign last_stop = !stop2_q || stop_cnt_q;
  assign frame_end = (state_q == ST_STOP) && cell_end && last_stop;

  // A new frame is loaded either from IDLE or directly at the end of the
  // previous stop cell, so back-to-back frames have no idle line between them.
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .push_i  (fifo_push),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Transmit FSM with registered line, busy and done outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cell_q     <= {CW{1'b0}};
      bit_q      <= {BW{1'b0}};
      stop_cnt_q <= 1'b0;
      shift_q    <= {DATA_W{1'b0}};
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= frame_end;

      // Cell counter only moves on baud_tick and restarts at every cell end,
      // which is the only point where a state or bit change can happen.
      if ((state_q != ST_IDLE) && baud_tick) begin
        cell_q <= cell_end ? {CW{1'b0}} : cell_q + CW'(1);
      end

      if (fifo_pop) begin
        // Snapshot the word and line configuration for the whole frame.
        state_q    <= ST_START;
        shift_q    <= fifo_rdata;
        par_en_q   <= parity_enabled(par_mode);
        par_bit_q  <= parity_bit(MAX_DATA_W'(fifo_rdata), par_mode);
        stop2_q    <= stop2;
        bit_q      <= {BW{1'b0}};
        stop_cnt_q <= 1'b0;
        cell_q     <= {CW{1'b0}};
        uart_tx_q  <= 1'b0;
        tx_busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
          end

          ST_START: begin
            if (cell_end) begin
              state_q   <= ST_DATA;
              uart_tx_q <= shift_q[0];
            end
          end

          ST_DATA: begin
            if (cell_end) begin
              if (last_bit) begin
                bit_q <= {BW{1'b0}};
                if (par_en_q) begin
                  state_q   <= ST_PARITY;
                  uart_tx_q <= par_bit_q;
                end else begin
                  state_q   <= ST_STOP;
                  uart_tx_q <= 1'b1;
                end
              end else begin
                // Next bit is already sitting at shift_q[1].
                bit_q     <= bit_q + BW'(1);
                shift_q   <= shift_q >> 1;
                uart_tx_q <= shift_q[1];
              end
            end
          end

          ST_PARITY: begin
            if (cell_end) begin
              state_q   <= ST_STOP;
              uart_tx_q <= 1'b1;
            end
          end

          ST_STOP: begin
            if (cell_end) begin
              if (last_stop) begin
                state_q    <= ST_IDLE;
                stop_cnt_q <= 1'b0;
                tx_busy_q  <= 1'b0;
                uart_tx_q  <= 1'b1;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q   <= ST_IDLE;
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uart_tx = uart_tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit cell, legal 4..32.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of 2, legal 2..64.
REQ-004 SHALL have port sys_clk, in, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, in, 1: asynchronous, active-high reset.
REQ-006 SHALL have port baud_tick, in, 1: one-cycle enable at OVERSAMPLE x baud rate.
REQ-007 SHALL have port par_mode, in, 2: 00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port stop2, in, 1: 1 selects two stop bits, 0 selects one.
REQ-009 SHALL have port tx_data, in, DATA_W: word to enqueue, LSB sent first.
REQ-010 SHALL have port tx_valid, in, 1: enqueue request.
REQ-011 SHALL have port tx_ready, out, 1: FIFO not full.
REQ-012 SHALL have port uart_tx, out, 1: serial line, idle high.
REQ-013 SHALL have port tx_busy, out, 1: high whenever FSM is not IDLE.
REQ-014 SHALL have port tx_done, out, 1: one-cycle pulse at end of each frame's last stop bit.
REQ-015 SHALL have port fifo_level, out, $clog2(FIFO_DEPTH)+1: entries currently held.

Function
REQ-016 SHALL accept a word when tx_valid and tx_ready are both high at a clock edge; tx_valid with tx_ready low is ignored, no data lost from FIFO.
REQ-017 SHALL derive tx_ready = (fifo_level != FIFO_DEPTH) combinationally from registered level.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with fifo_level > 0 SHALL pop head word into shift register, latch par_mode and stop2, and enter START next cycle; config changes mid-frame SHALL not affect the current frame.
REQ-020 SHALL hold each bit cell for exactly OVERSAMPLE baud_tick pulses; cell counter increments only on baud_tick and is cleared on every state/bit change; no cell advances without baud_tick.
REQ-021 SHALL drive uart_tx: IDLE 1, START 0, DATA shift_reg[0], PARITY computed bit, STOP 1; uart_tx SHALL be a registered output.
REQ-022 DATA SHALL send DATA_W bits LSB first, then go to PARITY if latched mode is even/odd, else STOP.
REQ-023 Parity bit SHALL be XOR of the DATA_W data bits for even, its inverse for odd.
REQ-024 STOP SHALL last 1 or 2 bit cells per latched stop2, then pulse tx_done for one cycle and return to IDLE.
REQ-025 Simultaneous push and pop in one cycle SHALL leave fifo_level unchanged and both operations take effect; when full, push is rejected even if pop occurs that cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; one extra level bit distinguishes full from empty.
REQ-027 Back-to-back frames SHALL start with at most one idle clock between STOP end and next START, zero baud_tick cells of idle line.
REQ-028 Transmitted frame content SHALL depend only on tx_data, par_mode, stop2; no data-pattern-dependent mode change or hidden state is permitted.

Reset
REQ-029 sys_rst high SHALL asynchronously force: state IDLE, uart_tx 1, tx_busy 0, tx_done 0, fifo_level 0, pointers 0, cell/bit counters 0, shift register 0.
REQ-030 Reset mid-frame SHALL abort the frame and flush the FIFO; first frame after release starts only on a new push.

Structure
REQ-031 State encoding enum and par_mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL reside in shared package uart_pkg.
REQ-032 FIFO SHALL be a separate sub-module uart_tx_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty/level ports).

Verification (DATA_W=8, OVERSAMPLE=16, FIFO_DEPTH=4, baud_tick every cycle unless stated)
REQ-033 Reset released, no push -> uart_tx=1, tx_ready=1, tx_busy=0, fifo_level=0 for 100 cycles.
REQ-034 Push 0x55, par_mode=00, stop2=0 -> line 0,1,0,1,0,1,0,1,0,1 each 16 cycles, 160 cycles total, single tx_done pulse.
REQ-035 Push 0xA7 even parity -> parity cell 1; same with odd -> parity cell 0; stop2=1 -> stop high 32 cycles.
REQ-036 baud_tick held low, push 6 words -> first popped, 4 queued, fifo_level=4, tx_ready=0, 6th rejected; then ticks on -> 5 frames back-to-back in order, 5 tx_done pulses.
REQ-037 sys_rst asserted during DATA bit 3 -> uart_tx=1 without clock edge, fifo_level=0, tx_busy=0; no frame after release until push.
REQ-038 Send 0xAA,0x55,0x22,0xFF,0x11 sequence -> each frame bit-exact per REQ-021..024, no mode change.
